instruction_fetch_unit: RTL and testbench

//  Initiator side of the instruction-memory read port: owns the PC and drives the

---
 rtl/instruction_fetch_unit_pkg.sv | 18 +
 rtl/instruction_fetch_unit_if_id_reg.sv | 37 +++
 rtl/instruction_fetch_unit.sv | 102 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants, fetch-state encoding and the fetch-address legality check
// for the instruction fetch unit.
package instruction_fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_e;

    // A fetch address is illegal when it is not word aligned or lies past the last word.
    function automatic logic addr_bad(input logic [31:0] addr, input logic [31:0] last_word);
        return (addr[1:0] != 2'b00) || (addr > last_word);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: load captures a fetched word, flush replaces the whole
// entry with a NOP (pc4 cleared, valid dropped), otherwise the entry holds.
module instruction_fetch_unit_if_id_reg
    import instruction_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc4,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_pc4   <= i_pc4;
            r_valid <= 1'b1;
        end
    end

    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction-memory address and
// fills the IF/ID register, handling stall, redirect/squash and sticky address faults.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'd100,
    parameter int          MEM_BYTES = 16384,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_instr,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_target,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic             fetch_fault,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

    fetch_state_e     r_state;
    fetch_state_e     w_state_next;
    logic [31:0]      r_pc;
    logic [31:0]      w_pc_next;
    logic [31:0]      w_pc_plus4;
    logic [CNT_W-1:0] r_count;
    logic             w_load;
    logic             w_flush;

    assign w_pc_plus4 = r_pc + WORD_BYTES;

    // A sequential fetch always delivers the current (legal) word; only the advance
    // to pc+4 is suppressed when that next address is illegal.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_load       = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (redirect) begin
                    w_flush = 1'b1;
                    if (addr_bad(redirect_target, LAST_WORD)) begin
                        w_state_next = ST_FAULT;
                    end else begin
                        w_pc_next = redirect_target;
                    end
                end else if (!stall) begin
                    w_load = 1'b1;
                    if (addr_bad(w_pc_plus4, LAST_WORD)) begin
                        w_state_next = ST_FAULT;
                    end else begin
                        w_pc_next = w_pc_plus4;
                    end
                end
            end
            ST_FAULT: begin
                w_flush = 1'b1;
            end
            default: begin
                w_state_next = ST_FAULT;
                w_flush      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
            r_pc    <= RESET_PC;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_load) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    instruction_fetch_unit_if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_instr (imem_instr),
        .i_pc4   (w_pc_plus4),
        .o_instr (if_id_instr),
        .o_pc4   (if_id_pc4),
        .o_valid (if_id_valid)
    );

    assign imem_addr   = r_pc;
    assign fetch_fault = (r_state == ST_FAULT);
    assign fetch_count = r_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: behavioural big-endian memory,
// cycle-level reference model, directed scenarios followed by randomized traffic.
module tb_instruction_fetch_unit;

    localparam int MEM_BYTES = 16384;
    localparam int CNT_W     = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_instr;
    logic             stall = 1'b0;
    logic             redirect = 1'b0;
    logic [31:0]      redirect_target = 32'd0;
    logic [31:0]      if_id_instr;
    logic [31:0]      if_id_pc4;
    logic             if_id_valid;
    logic             fetch_fault;
    logic [CNT_W-1:0] fetch_count;

    logic [7:0] mem [0:MEM_BYTES-1];

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [31:0]      m_pc = 32'd100;
    logic [31:0]      m_instr = 32'd0;
    logic [31:0]      m_pc4 = 32'd0;
    logic             m_valid = 1'b0;
    logic             m_fault = 1'b0;
    logic [CNT_W-1:0] m_count = '0;

    instruction_fetch_unit #(
        .RESET_PC  (32'd100),
        .MEM_BYTES (MEM_BYTES),
        .CNT_W     (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .if_id_instr     (if_id_instr),
        .if_id_pc4       (if_id_pc4),
        .if_id_valid     (if_id_valid),
        .fetch_fault     (fetch_fault),
        .fetch_count     (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (a > 32'(MEM_BYTES - 4)) return 32'hxxxx_xxxx;
        return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
    endfunction

    always_comb imem_instr = rd_word(imem_addr);

    function automatic logic illegal(input logic [31:0] a);
        return (a % 4 != 0) || (a + 4 > MEM_BYTES);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: apply one clock edge of behaviour using the inputs seen at that edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_pc = 32'd100; m_instr = 0; m_pc4 = 0; m_valid = 0; m_fault = 0; m_count = 0;
        end else if (m_fault) begin
            m_instr = 0; m_pc4 = 0; m_valid = 0;
        end else if (redirect) begin
            m_instr = 0; m_pc4 = 0; m_valid = 0;
            if (illegal(redirect_target)) m_fault = 1;
            else m_pc = redirect_target;
        end else if (!stall) begin
            m_instr = rd_word(m_pc);
            m_pc4   = m_pc + 4;
            m_valid = 1;
            m_count = m_count + 1'b1;
            if (illegal(m_pc + 4)) m_fault = 1;
            else m_pc = m_pc + 4;
        end
    end

    always @(negedge clk) begin
        chk("imem_addr", imem_addr, m_pc);
        chk("if_id_instr", if_id_instr, m_instr);
        chk("if_id_pc4", if_id_pc4, m_pc4);
        chk("if_id_valid", 32'(if_id_valid), 32'(m_valid));
        chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
        chk("fetch_count", 32'(fetch_count), 32'(m_count));
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic put_word(input int a, input logic [31:0] w);
        mem[a] = w[31:24]; mem[a+1] = w[23:16]; mem[a+2] = w[15:8]; mem[a+3] = w[7:0];
    endtask

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'($urandom);
        put_word(100, 32'h4808_0000);
        put_word(108, 32'hA1B2_C3D4);
        put_word(200, 32'hDEAD_BEEF);
        put_word(16380, 32'h1234_5678);

        // 1: reset then run
        step(); step();
        chk("rst_pc", imem_addr, 32'd100);
        chk("rst_valid", 32'(if_id_valid), 32'd0);
        chk("rst_count", 32'(fetch_count), 32'd0);
        chk("rst_instr", if_id_instr, 32'd0);
        rst_n = 1'b1;
        step();
        chk("t1_instr", if_id_instr, 32'h4808_0000);
        chk("t1_pc4", if_id_pc4, 32'd104);
        chk("t1_valid", 32'(if_id_valid), 32'd1);
        chk("t1_count", 32'(fetch_count), 32'd1);
        step();
        chk("t2_pc", imem_addr, 32'd108);

        // 2: stall 3 cycles at pc=108
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t2_stall_pc", imem_addr, 32'd108);
            chk("t2_stall_count", 32'(fetch_count), 32'd2);
            chk("t2_stall_pc4", if_id_pc4, 32'd108);
        end
        stall = 1'b0;
        step();
        chk("t2_resume_instr", if_id_instr, 32'hA1B2_C3D4);
        chk("t2_resume_count", 32'(fetch_count), 32'd3);

        // 3: redirect wins over stall
        stall = 1'b1; redirect = 1'b1; redirect_target = 32'd200;
        step();
        chk("t3_pc", imem_addr, 32'd200);
        chk("t3_squash", if_id_instr, 32'd0);
        chk("t3_valid", 32'(if_id_valid), 32'd0);
        stall = 1'b0; redirect = 1'b0;
        step();
        chk("t3_instr", if_id_instr, 32'hDEAD_BEEF);
        chk("t3_pc4", if_id_pc4, 32'd204);
        chk("t3_count", 32'(fetch_count), 32'd4);

        // 4: misaligned redirect -> sticky fault
        redirect = 1'b1; redirect_target = 32'd202;
        step();
        chk("t4_fault", 32'(fetch_fault), 32'd1);
        chk("t4_pc", imem_addr, 32'd204);
        chk("t4_valid", 32'(if_id_valid), 32'd0);
        redirect_target = 32'd300;
        for (int k = 0; k < 3; k++) begin
            redirect = k[0]; stall = k[1];
            step();
            chk("t4_hold_pc", imem_addr, 32'd204);
            chk("t4_hold_fault", 32'(fetch_fault), 32'd1);
        end
        redirect = 1'b0; stall = 1'b0;
        rst_n = 1'b0;
        step();
        chk("t4_rst_fault", 32'(fetch_fault), 32'd0);
        chk("t4_rst_pc", imem_addr, 32'd100);
        rst_n = 1'b1;

        // 5: sequential fetch off the end of memory
        redirect = 1'b1; redirect_target = 32'd16380;
        step();
        redirect = 1'b0;
        step();
        chk("t5_instr", if_id_instr, 32'h1234_5678);
        chk("t5_pc4", if_id_pc4, 32'd16384);
        chk("t5_fault", 32'(fetch_fault), 32'd1);
        chk("t5_pc", imem_addr, 32'd16380);
        step();
        chk("t5_after_valid", 32'(if_id_valid), 32'd0);

        // 6: reset during redirect
        rst_n = 1'b0; redirect = 1'b1; redirect_target = 32'd400;
        step();
        chk("t6_pc", imem_addr, 32'd100);
        chk("t6_count", 32'(fetch_count), 32'd0);
        chk("t6_fault", 32'(fetch_fault), 32'd0);
        rst_n = 1'b1; redirect = 1'b0;
        step();
        chk("t6_resume_instr", if_id_instr, 32'h4808_0000);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            stall    = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 9))
                0:       redirect_target = 32'($urandom_range(0, 4095) * 4 + $urandom_range(1, 3));
                1:       redirect_target = 32'(MEM_BYTES + $urandom_range(0, 64) * 4);
                2, 3:    redirect_target = 32'(MEM_BYTES - 4 * $urandom_range(1, 4));
                default: redirect_target = 32'($urandom_range(0, 4095) * 4);
            endcase
            rst_n = !(($urandom_range(0, 99) == 0) || (fetch_fault && $urandom_range(0, 3) == 0));
            step();
        end
        rst_n = 1'b1; stall = 1'b0; redirect = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
